// File: rtl/sync_counter_pkg.sv
// ---------------------------------------------------------------------------
// sync_counter_pkg
// Shared definitions for the synchronous counter family.
//   cnt_state_t   : one-shot controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default counter width in bits
//   clamp_load    : saturates a parallel-load value at the terminal count
// ---------------------------------------------------------------------------
package sync_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Any value above the terminal count is pulled down to it, so a load
    // can never place the counter in an unreachable state.
    function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                               input logic [31:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/d_ff_sync_rstn.sv
// ---------------------------------------------------------------------------
// d_ff_sync_rstn
// One-bit D register with synchronous active-low reset.
//   RESET_VAL : value taken when rst_ni is low at a rising clk edge
// Ports:
//   clk    in  clock
//   rst_ni in  synchronous active-low reset
//   d_i    in  next-state bit
//   q_o    out registered bit
// ---------------------------------------------------------------------------
module d_ff_sync_rstn #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/sync_up_counter.sv
// ---------------------------------------------------------------------------
// sync_up_counter
// Synchronous binary up counter, 0..MAX_COUNT then wrap, with count enable,
// clamped parallel load and a tc/carry_out pair for cascading.
// Optional build macro SYNC_UP_COUNTER_ONESHOT_EN adds start/done and a
// three-state controller that stops at MAX_COUNT instead of wrapping.
// Parameters:
//   WIDTH     : counter width (1..31)
//   MAX_COUNT : terminal value, <= 2^WIDTH-1
//   RESET_VAL : value after reset, <= MAX_COUNT
// Ports:
//   clk       in  clock, rising edge
//   rst       in  synchronous active-low reset
//   en        in  count enable
//   load      in  parallel load strobe (beats en)
//   load_val  in  load value, clamped to MAX_COUNT
//   start     in  (one-shot build) begin a run from 0
//   done      out (one-shot build) run finished, count frozen
//   out       out current count
//   tc        out out == MAX_COUNT
//   carry_out out tc & en, feeds the next stage's en
// ---------------------------------------------------------------------------
module sync_up_counter
    import sync_counter_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_COUNT = 15,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef SYNC_UP_COUNTER_ONESHOT_EN
    input  logic             start,
    output logic             done,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             carry_out
);

    generate
        if (WIDTH < 1 || WIDTH > 31 || MAX_COUNT < 0 ||
            MAX_COUNT > (2 ** WIDTH) - 1 ||
            RESET_VAL < 0 || RESET_VAL > MAX_COUNT) begin : g_bad_params
            $error("sync_up_counter: illegal WIDTH/MAX_COUNT/RESET_VAL");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] inc_bit;
    logic [WIDTH-1:0] inc_carry;
    logic             at_max;
    logic             sel_load;
    logic             sel_zero;
    logic             sel_inc;

    assign at_max       = (cnt_q == MAX_W);
    assign load_clamped = WIDTH'(clamp_load(32'(load_val), 32'(MAX_COUNT)));

    // Ripple increment written bit by bit; the top carry is never needed
    // because the MAX_COUNT compare handles the wrap.
    assign inc_carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign inc_bit[gi] = cnt_q[gi] ^ inc_carry[gi];
            if (gi < WIDTH - 1) begin : g_carry
                assign inc_carry[gi+1] = cnt_q[gi] & inc_carry[gi];
            end

            // Priority below reset (handled in the cell): load > clear > inc > hold
            assign cnt_d[gi] = sel_load ? load_clamped[gi] :
                               sel_zero ? 1'b0             :
                               sel_inc  ? inc_bit[gi]      :
                                          cnt_q[gi];

            d_ff_sync_rstn #(
                .RESET_VAL (RST_W[gi])
            ) u_cnt_bit (
                .clk    (clk),
                .rst_ni (rst),
                .d_i    (cnt_d[gi]),
                .q_o    (cnt_q[gi])
            );
        end
    endgenerate

`ifdef SYNC_UP_COUNTER_ONESHOT_EN
    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       in_run;

    assign in_run = (state_q == ST_RUN);

    // start only matters outside RUN; at the terminal count the counter
    // holds and hands over to DONE instead of wrapping.
    assign sel_load = load;
    assign sel_zero = !load && start && !in_run;
    assign sel_inc  = !load && in_run && en && !at_max;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_d = ST_RUN;
                ST_RUN:  if (en && at_max) state_d = ST_DONE;
                ST_DONE: if (start) state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_state_bit
            d_ff_sync_rstn #(
                .RESET_VAL (ST_IDLE[gi])
            ) u_state_bit (
                .clk    (clk),
                .rst_ni (rst),
                .d_i    (state_d[gi]),
                .q_o    (state_q[gi])
            );
        end
    endgenerate

    assign done      = (state_q == ST_DONE);
    assign carry_out = at_max && en && in_run;
`else
    assign sel_load  = load;
    assign sel_zero  = !load && en && at_max;
    assign sel_inc   = !load && en && !at_max;
    assign carry_out = at_max && en;
`endif

    assign out = cnt_q;
    assign tc  = at_max;

endmodule

// File: tb/tb_sync_up_counter.sv
module tb_sync_up_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for A (defaults) and B (MAX 9, RESET_VAL 3)
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] out_a, out_b;
    logic       tc_a, tc_b, co_a, co_b;

    // Cascade pair, each MAX 9
    logic       rst_c = 1'b0;
    logic       en_c = 1'b0;
    logic [3:0] lo_out, hi_out;
    logic       lo_tc, hi_tc, lo_co, hi_co;

`ifdef SYNC_UP_COUNTER_ONESHOT_EN
    logic start = 1'b0;
    logic done_a, done_b, done_lo, done_hi;
`endif

    sync_up_counter #(.WIDTH(4), .MAX_COUNT(15), .RESET_VAL(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
`ifdef SYNC_UP_COUNTER_ONESHOT_EN
        .start(start), .done(done_a),
`endif
        .out(out_a), .tc(tc_a), .carry_out(co_a)
    );

    sync_up_counter #(.WIDTH(4), .MAX_COUNT(9), .RESET_VAL(3)) u_b (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
`ifdef SYNC_UP_COUNTER_ONESHOT_EN
        .start(start), .done(done_b),
`endif
        .out(out_b), .tc(tc_b), .carry_out(co_b)
    );

    sync_up_counter #(.WIDTH(4), .MAX_COUNT(9), .RESET_VAL(0)) u_lo (
        .clk(clk), .rst(rst_c), .en(en_c), .load(1'b0), .load_val(4'd0),
`ifdef SYNC_UP_COUNTER_ONESHOT_EN
        .start(1'b0), .done(done_lo),
`endif
        .out(lo_out), .tc(lo_tc), .carry_out(lo_co)
    );

    sync_up_counter #(.WIDTH(4), .MAX_COUNT(9), .RESET_VAL(0)) u_hi (
        .clk(clk), .rst(rst_c), .en(lo_co), .load(1'b0), .load_val(4'd0),
`ifdef SYNC_UP_COUNTER_ONESHOT_EN
        .start(1'b0), .done(done_hi),
`endif
        .out(hi_out), .tc(hi_tc), .carry_out(hi_co)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour straight from the counter's rules.
    function automatic int ref_next(input int cur, input bit r, input bit e,
                                    input bit l, input int lv, input int mx,
                                    input int rv);
        if (!r) return rv;
        if (l) return (lv > mx) ? mx : lv;
        if (e) return (cur == mx) ? 0 : cur + 1;
        return cur;
    endfunction

    typedef struct {
        logic       rst;
        logic       en;
        logic       load;
        logic [3:0] lv;
        int         exp_a;
        int         exp_b;
    } vec_t;

    vec_t tbl[17];

    initial begin
`ifndef SYNC_UP_COUNTER_ONESHOT_EN
        int m_a, m_b;
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 4'd7,  0,  3};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'd0,  0,  3};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1,  4};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 4'd0,  2,  5};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'd0,  3,  6};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'd0,  4,  7};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 4'd0,  5,  8};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 4'd0,  5,  8};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 4'd0,  6,  9};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'd0,  7,  0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 4'd12, 12, 9};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 4'd0,  12, 9};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 4'd13, 13, 9};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 4'd0,  14, 0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 4'd0,  15, 1};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 4'd0,  0,  2};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 4'd5,  0,  3};

        // Table-driven vectors
        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; load = tbl[i].load; load_val = tbl[i].lv;
            tick();
            chk($sformatf("tbl%0d_out_a", i), int'(out_a), tbl[i].exp_a);
            chk($sformatf("tbl%0d_out_b", i), int'(out_b), tbl[i].exp_b);
            chk($sformatf("tbl%0d_tc_a", i), int'(tc_a), int'(tbl[i].exp_a == 15));
            chk($sformatf("tbl%0d_tc_b", i), int'(tc_b), int'(tbl[i].exp_b == 9));
            chk($sformatf("tbl%0d_co_a", i), int'(co_a), int'(tbl[i].exp_a == 15 && tbl[i].en));
            chk($sformatf("tbl%0d_co_b", i), int'(co_b), int'(tbl[i].exp_b == 9 && tbl[i].en));
        end

        // Reset two edges, then count 20 cycles: 0..15,0..3
        rst = 1'b0; en = 1'b0; load = 1'b0;
        tick(); tick();
        chk("cnt_reset_a", int'(out_a), 0);
        chk("cnt_reset_b", int'(out_b), 3);
        rst = 1'b1; en = 1'b1;
        for (int k = 1; k < 20; k++) begin
            tick();
            chk($sformatf("cnt%0d_out", k), int'(out_a), k % 16);
            chk($sformatf("cnt%0d_tc", k), int'(tc_a), int'(k % 16 == 15));
            chk($sformatf("cnt%0d_co", k), int'(co_a), int'(k % 16 == 15));
        end

        // Reset mid-count with en and load asserted
        load = 1'b1; load_val = 4'd7; en = 1'b0;
        tick();
        chk("midrst_pre_a", int'(out_a), 7);
        rst = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd9;
        tick();
        chk("midrst_a", int'(out_a), 0);
        chk("midrst_b", int'(out_b), 3);

        // Randomized against the reference model
        m_a = 0; m_b = 3;
        for (int c = 0; c < 300; c++) begin
            bit r, e, l;
            int lv;
            r  = ($urandom_range(0, 15) != 0);
            e  = $urandom_range(0, 3) != 0;
            l  = ($urandom_range(0, 7) == 0);
            lv = $urandom_range(0, 15);
            rst = r; en = e; load = l; load_val = 4'(lv);
            tick();
            m_a = ref_next(m_a, r, e, l, lv, 15, 0);
            m_b = ref_next(m_b, r, e, l, lv, 9, 3);
            chk($sformatf("rnd%0d_out_a", c), int'(out_a), m_a);
            chk($sformatf("rnd%0d_out_b", c), int'(out_b), m_b);
            chk($sformatf("rnd%0d_co_a", c), int'(co_a), int'(m_a == 15 && e));
            chk($sformatf("rnd%0d_co_b", c), int'(co_b), int'(m_b == 9 && e));
        end

        // Two-stage BCD cascade: 00..99 then back to 00
        rst_c = 1'b0; en_c = 1'b0;
        tick();
        rst_c = 1'b1; en_c = 1'b1;
        chk("casc_reset", int'(hi_out) * 10 + int'(lo_out), 0);
        for (int k = 1; k <= 100; k++) begin
            tick();
            chk($sformatf("casc%0d_val", k), int'(hi_out) * 10 + int'(lo_out), k % 100);
            chk($sformatf("casc%0d_hi_co", k), int'(hi_co), int'(k % 100 == 99));
            chk($sformatf("casc%0d_tc", k), int'(hi_tc) * 2 + int'(lo_tc),
                int'(k % 100 >= 90) * 2 + int'(k % 10 == 9));
        end
`else
        // One-shot run on A (MAX 15) and B (MAX 9)
        rst = 1'b0; en = 1'b0; load = 1'b0; start = 1'b0;
        tick();
        rst = 1'b1; en = 1'b1;
        tick();
        chk("os_idle_out", int'(out_a), 0);
        chk("os_idle_done", int'(done_a), 0);
        chk("os_idle_co", int'(co_a), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("os_start_out", int'(out_a), 0);
        chk("os_start_out_b", int'(out_b), 0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("os_run%0d_out", k), int'(out_a), k);
            chk($sformatf("os_run%0d_done", k), int'(done_a), 0);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("os_frz%0d_out", k), int'(out_a), 15);
            chk($sformatf("os_frz%0d_done", k), int'(done_a), 1);
            chk($sformatf("os_frz%0d_co", k), int'(co_a), 0);
        end
        chk("os_b_out", int'(out_b), 9);
        chk("os_b_done", int'(done_b), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("os_restart_out", int'(out_a), 0);
        chk("os_restart_done", int'(done_a), 0);
        tick();
        chk("os_resume_out", int'(out_a), 1);
        load = 1'b1; load_val = 4'd12;
        tick();
        load = 1'b0;
        chk("os_load_out_b", int'(out_b), 9);
        chk("os_load_done_b", int'(done_b), 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_up_counter.md
Name: sync_up_counter

Overview:
Synchronous binary up counter: every register bit updates on the same clock edge. It is the up-counting counterpart to the team's synchronous down counter. Counts from 0 to a programmable terminal value MAX_COUNT, then wraps. Adds count enable, synchronous parallel load, and a terminal-count/carry pair so several instances cascade into wider counters.

Parameters:
WIDTH, 4, counter width in bits
MAX_COUNT, 15, terminal value; must be <= 2^WIDTH-1
RESET_VAL, 0, value loaded on reset; must be <= MAX_COUNT

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-low reset; sampled on rising clk
en  input  1  count enable; count advances only when high
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value captured when load is high
out  output  WIDTH  current count, driven directly from register
tc  output  1  terminal count: high while out == MAX_COUNT
carry_out  output  1  tc & en, combinational; drives the next stage's en in a cascade

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-low: rst==0 at a rising clk edge resets the block. There is no asynchronous path.
- Reset values: out = RESET_VAL. tc = (RESET_VAL == MAX_COUNT). carry_out follows tc & en.
- Per-edge priority: reset > load > en > hold.
- Load: out <= min(load_val, MAX_COUNT). A load_val above MAX_COUNT clamps to MAX_COUNT and never enters an illegal state. Load overrides en in the same cycle.
- Count: en=1 and out < MAX_COUNT gives out <= out+1. en=1 and out == MAX_COUNT wraps to 0. en=0 holds out.
- Latency: out changes one cycle after the edge where en or load is sampled. tc and carry_out are combinational from the out register and en, with no added latency.
- carry_out is high in exactly the cycle before a wrap. This lets an upper-stage instance advance on the same edge that the lower stage wraps.
- Reset mid-count: the next edge with rst==0 forces RESET_VAL regardless of en or load.
- Non-power-of-two MAX_COUNT (e.g. 9, for BCD): values MAX_COUNT+1 .. 2^WIDTH-1 are unreachable.
- Elaboration error if MAX_COUNT > 2^WIDTH-1 or RESET_VAL > MAX_COUNT.
- Next-state logic is written as continuous assignments per bit. Storage uses per-bit register cells only.

Optional Feature:
Macro SYNC_UP_COUNTER_ONESHOT_EN.
- Defined: adds input start (1 bit) and output done (1 bit), plus a 3-state FSM.
  - IDLE: out holds; done=0. start=1 loads 0 and moves to RUN.
  - RUN: counts on en. At the edge where out == MAX_COUNT and en=1, out holds at MAX_COUNT (no wrap) and the FSM moves to DONE.
  - DONE: done=1 and out is frozen. start=1 returns to RUN with out <= 0, which allows back-to-back restarts.
  - load in any state: applies clamped load_val and forces the state to RUN.
  - Reset: state IDLE, done=0.
  - carry_out is suppressed (0) in IDLE and DONE.
- Undefined: no start or done ports, no FSM; free-running wrap behaviour as above.

Decomposition:
- Package sync_counter_pkg:
  - enum cnt_state_t {IDLE, RUN, DONE}
  - default WIDTH constant
  - function clamp_load(val, max)
- One sub-module: d_ff_sync_rstn, a 1-bit D register with synchronous active-low reset and a parameterized reset value. It is instantiated WIDTH times (plus 2 for FSM state when the macro is enabled).

Test Plan:
- rst=0 for 2 edges, then rst=1, en=1 for 20 cycles (defaults) -> out 0,1,...,15,0,1,2,3. tc=1 only when out=15. carry_out=1 in that same cycle.
- en toggled 1,0,0,1 from out=5 -> out 6,6,6,7. No change while en=0.
- load=1, load_val=12 with en=1 at the same edge -> out=12 (load wins). With WIDTH=4, MAX_COUNT=9: load_val=13 -> out=9, tc=1.
- Cascade of two instances, lower carry_out driving upper en (MAX_COUNT=9 each) -> pair counts 00..99, then wraps to 00 at cycle 100.
- rst=0 asserted while out=7, en=1, load=1 -> next edge out=RESET_VAL. With RESET_VAL=3 build: out=3.
- ONESHOT_EN build: start pulse, en=1 -> out 0..15, then done=1 with out frozen at 15 for 5 cycles. A second start gives out=0, done=0, and counting resumes.
